// File: rtl/shift_fifo_pkg.sv
// ============================================================================
// Module : shift_fifo_pkg
// Brief  : Shared constants for the shifting-register FIFO slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_fifo_pkg;

   localparam int c_core_data_width = 32;
   localparam int c_fifo_depth      = 4;

endpackage

`default_nettype wire

// File: rtl/shift_fifo_if.sv
// ============================================================================
// Module : shift_fifo_if
// Brief  : Push/pop handshake bundle for shift_fifo; slave = FIFO side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface shift_fifo_if
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH = c_core_data_width,
   parameter int DEPTH = c_fifo_depth
);

   logic                       flush;
   logic                       push_valid;
   logic                       push_ready;
   logic [WIDTH-1:0]           push_data;
   logic                       pop_valid;
   logic                       pop_ready;
   logic [WIDTH-1:0]           pop_data;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                       full;
   logic                       empty;

   modport master (
      output flush, push_valid, push_data, pop_ready,
      input  push_ready, pop_valid, pop_data, count, full, empty
   );

   modport slave (
      input  flush, push_valid, push_data, pop_ready,
      output push_ready, pop_valid, pop_data, count, full, empty
   );

endinterface

`default_nettype wire

// File: rtl/shift_fifo_slot.sv
// ============================================================================
// Module : shift_fifo_slot
// Brief  : One FIFO entry: clear / load / shift-in / hold.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_fifo_slot
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH = c_core_data_width
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_clear,
   input  wire logic             i_load,
   input  wire logic             i_shift,
   input  wire logic [WIDTH-1:0] i_load_data,
   input  wire logic [WIDTH-1:0] i_shift_data,
   output logic      [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_data;

   // A load wins over a shift: on push&pop the tail slot takes the new word.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_load_data;
      end else if (i_shift) begin
         r_data <= i_shift_data;
      end
   end

   assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/shift_fifo.sv
// ============================================================================
// Module : shift_fifo
// Brief  : Shifting-register FIFO; head word always lives in slot 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_fifo
   import shift_fifo_pkg::*;
#(
   parameter int WIDTH = c_core_data_width,
   parameter int DEPTH = c_fifo_depth
) (
   input  wire logic   clk,
   input  wire logic   reset,
   shift_fifo_if.slave bus
);

   localparam int                   c_cnt_w    = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w-1:0]   c_full_cnt = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0]   c_one      = c_cnt_w'(1);

   logic [c_cnt_w-1:0] r_count;
   logic [c_cnt_w-1:0] w_load_idx;
   logic [WIDTH-1:0]   w_regs [DEPTH];
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;

   assign w_full  = (r_count == c_full_cnt);
   assign w_empty = (r_count == '0);
   assign w_push  = bus.push_valid & ~w_full;
   assign w_pop   = bus.pop_ready & ~w_empty;

   // With a concurrent pop the tail has already moved down one slot.
   assign w_load_idx = w_pop ? (r_count - c_one) : r_count;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_slot
         logic [WIDTH-1:0] w_shift_in;

         if (i == DEPTH - 1) begin : g_tail
            assign w_shift_in = '0;
         end else begin : g_body
            assign w_shift_in = w_regs[i+1];
         end

         shift_fifo_slot #(
            .WIDTH (WIDTH)
         ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .i_clear      (bus.flush),
            .i_load       (w_push && (w_load_idx == c_cnt_w'(i))),
            .i_shift      (w_pop),
            .i_load_data  (bus.push_data),
            .i_shift_data (w_shift_in),
            .o_data       (w_regs[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         r_count <= '0;
      end else if (w_push && !w_pop) begin
         r_count <= r_count + c_one;
      end else if (w_pop && !w_push) begin
         r_count <= r_count - c_one;
      end
   end

   assign bus.push_ready = ~w_full;
   assign bus.pop_valid  = ~w_empty;
   assign bus.pop_data   = w_regs[0];
   assign bus.count      = r_count;
   assign bus.full       = w_full;
   assign bus.empty      = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_shift_fifo.sv
// ============================================================================
// Module : tb_shift_fifo
// Brief  : Scoreboard bench for shift_fifo against a queue reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_fifo;
   import shift_fifo_pkg::*;

   localparam int W = c_core_data_width;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   shift_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

   shift_fifo #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [W-1:0] sb [$];
   int           n_tests = 0;
   int           n_fail  = 0;
   bit           mon_en  = 1'b0;
   logic [W-1:0] seq_abcd [4] = '{32'hA, 32'hB, 32'hC, 32'hD};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model queue is updated on the edge itself.
   task automatic step(input logic rs, input logic fl, input logic pv,
                       input logic [W-1:0] pd, input logic pr);
      bit acc;
      reset          = rs;
      bus.flush      = fl;
      bus.push_valid = pv;
      bus.push_data  = pd;
      bus.pop_ready  = pr;
      acc = pv && !fl && !rs && (sb.size() < D);
      @(posedge clk);
      if (rs || fl) sb.delete();
      else if (acc) sb.push_back(pd);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en && reset === 1'b0) begin
         automatic int n = sb.size();
         chk("count",       64'(bus.count), 64'(n));
         chk("count_bound", 64'(bus.count <= D), 64'(1));
         chk("empty",       64'(bus.empty), 64'(n == 0));
         chk("full",        64'(bus.full), 64'(n == D));
         chk("push_ready",  64'(bus.push_ready), 64'(n < D));
         chk("pop_valid",   64'(bus.pop_valid), 64'(n != 0));
         chk("pop_data",    64'(bus.pop_data), (n != 0) ? 64'(sb[0]) : 64'(0));
         if (bus.pop_valid && bus.pop_ready && !bus.flush) begin
            if (n == 0) begin
               chk("pop_when_empty", 64'(bus.pop_valid), 64'(0));
            end else begin
               chk("pop_order", 64'(bus.pop_data), 64'(sb[0]));
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      bit rs, fl, pv, pr;
      int pct_pop;

      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
      mon_en = 1'b1;
      chk("rst_count",      64'(bus.count), 64'(0));
      chk("rst_empty",      64'(bus.empty), 64'(1));
      chk("rst_full",       64'(bus.full), 64'(0));
      chk("rst_push_ready", 64'(bus.push_ready), 64'(1));
      chk("rst_pop_valid",  64'(bus.pop_valid), 64'(0));
      chk("rst_pop_data",   64'(bus.pop_data), 64'(0));

      // Fill then drain in order.
      for (int k = 0; k < 4; k++) step(0, 0, 1, seq_abcd[k], 0);
      chk("fill_full",       64'(bus.full), 64'(1));
      chk("fill_push_ready", 64'(bus.push_ready), 64'(0));
      chk("fill_count",      64'(bus.count), 64'(4));
      for (int k = 0; k < 4; k++) begin
         chk("drain_head", 64'(bus.pop_data), 64'(seq_abcd[k]));
         step(0, 0, 0, '0, 1);
      end
      chk("drain_empty",    64'(bus.empty), 64'(1));
      chk("drain_pop_data", 64'(bus.pop_data), 64'(0));

      // Push offered at full with a pop: word must be dropped.
      for (int k = 0; k < 4; k++) step(0, 0, 1, seq_abcd[k], 0);
      step(0, 0, 1, 32'hE, 1);
      chk("fullblk_count", 64'(bus.count), 64'(3));
      for (int k = 1; k < 4; k++) begin
         chk("fullblk_head", 64'(bus.pop_data), 64'(seq_abcd[k]));
         step(0, 0, 0, '0, 1);
      end
      chk("fullblk_empty", 64'(bus.empty), 64'(1));

      // Simultaneous push and pop at count 2.
      step(0, 0, 1, 32'h1, 0);
      step(0, 0, 1, 32'h2, 0);
      chk("simul_head_before", 64'(bus.pop_data), 64'(1));
      step(0, 0, 1, 32'h3, 1);
      chk("simul_count", 64'(bus.count), 64'(2));
      chk("simul_head",  64'(bus.pop_data), 64'(2));
      step(0, 0, 0, '0, 1);
      chk("simul_tail", 64'(bus.pop_data), 64'(3));
      step(0, 0, 0, '0, 1);

      // Pop request while empty.
      step(0, 0, 0, '0, 1);
      step(0, 0, 0, '0, 1);
      chk("emptypop_count",     64'(bus.count), 64'(0));
      chk("emptypop_pop_valid", 64'(bus.pop_valid), 64'(0));

      // Flush mid-stream drops the concurrent push.
      for (int k = 0; k < 3; k++) step(0, 0, 1, seq_abcd[k], 0);
      step(0, 1, 1, 32'h55, 0);
      chk("flush_count",    64'(bus.count), 64'(0));
      chk("flush_pop_data", 64'(bus.pop_data), 64'(0));
      chk("flush_empty",    64'(bus.empty), 64'(1));

      // Random traffic with shifting pop pressure so the FIFO visits every level.
      for (int c = 0; c < 3000; c++) begin
         pct_pop = ((c / 200) % 3 == 0) ? 20 : (((c / 200) % 3 == 1) ? 80 : 50);
         rs = ($urandom_range(0, 199) == 0);
         fl = ($urandom_range(0, 49) == 0);
         pv = ($urandom_range(0, 99) < 60);
         pr = ($urandom_range(0, 99) < pct_pop);
         step(rs, fl, pv, $urandom, pr);
      end

      for (int k = 0; k <= D; k++) step(0, 0, 0, '0, 1);
      chk("final_empty", 64'(bus.empty), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
